// File: rtl/irq_ctrl_if.sv
// rtl/irq_ctrl_if.sv - configuration bus and CPU interrupt handshake bundle for irq_ctrl
//
// Purpose: groups the register-access strobe/select/data signals and the
// request/ack/eoi handshake between irq_ctrl and the control unit.
// Ports (signals):
//   cfg_we, cfg_sel, cfg_wdata   register write strobe, select, data (master -> slave)
//   cfg_rdata                    combinational read of the selected register (slave -> master)
//   int_req, int_id              registered request and channel id (slave -> master)
//   int_ack, int_eoi             call-interrupt / return-from-interrupt cycles (master -> slave)
//   nest_level                   number of channels in service (slave -> master)
//   spur_ack, eoi_uflow          sticky protocol error flags (slave -> master)
// Modports: master = control unit side, slave = irq_ctrl side.
interface irq_ctrl_if #(
    parameter int N_IRQ = 8,
    parameter int ID_W  = 3,
    parameter int LVL_W = 3
);
    logic             cfg_we;
    logic [2:0]       cfg_sel;
    logic [N_IRQ-1:0] cfg_wdata;
    logic [N_IRQ-1:0] cfg_rdata;
    logic             int_req;
    logic [ID_W-1:0]  int_id;
    logic             int_ack;
    logic             int_eoi;
    logic [LVL_W-1:0] nest_level;
    logic             spur_ack;
    logic             eoi_uflow;

    modport master (
        output cfg_we, cfg_sel, cfg_wdata, int_ack, int_eoi,
        input  cfg_rdata, int_req, int_id, nest_level, spur_ack, eoi_uflow
    );

    modport slave (
        input  cfg_we, cfg_sel, cfg_wdata, int_ack, int_eoi,
        output cfg_rdata, int_req, int_id, nest_level, spur_ack, eoi_uflow
    );
endinterface

// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - parametrised interrupt controller with priority nesting
//
// Purpose: synchronises N_IRQ raw interrupt lines, latches them as pending
// (edge or level mode per channel), and presents a registered request plus
// channel id for the highest-priority unmasked channel that may preempt the
// handler currently in service. Tracks in-service channels up to NEST_DEPTH.
// Ports:
//   clk      system clock, rising edge
//   reset    asynchronous active-low reset
//   irq_in   raw interrupt lines, asynchronous to clk
//   bus      irq_ctrl_if.slave: cfg register access, int_req/int_id/int_ack/
//            int_eoi handshake, nest_level, spur_ack/eoi_uflow flags
// Register map (cfg_sel): 0 mask, 1 mode (1=edge), 2 pending (W1C),
//   3 in_service (write ORs into pending of edge channels), 4 flags
//   {eoi_uflow, spur_ack} (any write clears), 5..7 read 0.
module irq_ctrl #(
    parameter int N_IRQ       = 8,
    parameter int ID_W        = 3,
    parameter int NEST_DEPTH  = 4,
    parameter int LVL_W       = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IRQ-1:0] irq_in,
    irq_ctrl_if.slave        bus
);

    localparam logic [2:0] SEL_MASK  = 3'd0;
    localparam logic [2:0] SEL_MODE  = 3'd1;
    localparam logic [2:0] SEL_PEND  = 3'd2;
    localparam logic [2:0] SEL_INSV  = 3'd3;
    localparam logic [2:0] SEL_FLAGS = 3'd4;

    localparam logic [N_IRQ-1:0] ONE       = N_IRQ'(1);
    localparam logic [LVL_W-1:0] LVL_ONE   = LVL_W'(1);
    localparam logic [LVL_W-1:0] LVL_LIMIT = LVL_W'(NEST_DEPTH);

    // Synchroniser chain; sync_q[SYNC_STAGES-1] is the usable line value.
    logic [N_IRQ-1:0] sync_q [SYNC_STAGES];
    logic [N_IRQ-1:0] s;
    logic [N_IRQ-1:0] s_d;

    logic [N_IRQ-1:0] mask_q;
    logic [N_IRQ-1:0] mode_q;
    logic [N_IRQ-1:0] pending_q;
    logic [N_IRQ-1:0] in_service_q;
    logic             int_req_q;
    logic [ID_W-1:0]  int_id_q;
    logic [LVL_W-1:0] nest_level_q;
    logic             spur_ack_q;
    logic             eoi_uflow_q;

    logic [N_IRQ-1:0] rise;
    logic [N_IRQ-1:0] cur_onehot;
    logic [N_IRQ-1:0] prio_mask;
    logic [N_IRQ-1:0] cand;
    logic [ID_W-1:0]  best;
    logic [N_IRQ-1:0] id_onehot;
    logic             ack_ok;
    logic             eoi_ok;
    logic             wr_mask;
    logic             wr_mode;
    logic             wr_w1c;
    logic             wr_trig;
    logic             wr_flags;
    logic [N_IRQ-1:0] mode_flip;
    logic [N_IRQ-1:0] edge_set;
    logic [N_IRQ-1:0] edge_clr;
    logic [N_IRQ-1:0] edge_next;
    logic [N_IRQ-1:0] pending_n;
    logic [N_IRQ-1:0] in_service_n;
    logic [LVL_W-1:0] nest_level_n;
    logic             int_req_n;
    logic [ID_W-1:0]  int_id_n;
    logic [N_IRQ-1:0] rdata;

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        rise = s & ~s_d;

        // Lowest set bit of in_service is the handler currently running.
        cur_onehot = in_service_q & (~in_service_q + ONE);
        // Bits strictly below the lowest in-service bit (all ones when idle):
        // only those channels may preempt, and none of them is in service.
        prio_mask  = ~in_service_q & (in_service_q - ONE);
        cand       = pending_q & mask_q & prio_mask;

        best = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (cand[i]) begin
                best = ID_W'(i);
            end
        end

        id_onehot = ONE << int_id_q;
        ack_ok    = bus.int_ack && int_req_q;
        eoi_ok    = bus.int_eoi && (nest_level_q != '0);

        wr_mask  = bus.cfg_we && (bus.cfg_sel == SEL_MASK);
        wr_mode  = bus.cfg_we && (bus.cfg_sel == SEL_MODE);
        wr_w1c   = bus.cfg_we && (bus.cfg_sel == SEL_PEND);
        wr_trig  = bus.cfg_we && (bus.cfg_sel == SEL_INSV);
        wr_flags = bus.cfg_we && (bus.cfg_sel == SEL_FLAGS);

        mode_flip = wr_mode ? (bus.cfg_wdata ^ mode_q) : '0;

        // Edge channels: a set event beats a same-cycle clear.
        edge_set  = rise | (wr_trig ? bus.cfg_wdata : '0);
        edge_clr  = (wr_w1c ? bus.cfg_wdata : '0) | (ack_ok ? id_onehot : '0);
        edge_next = edge_set | (pending_q & ~edge_clr);

        // Level channels simply follow the synchronised line.
        pending_n = ~mode_flip & ((mode_q & edge_next) | (~mode_q & s));

        // Eoi retires the old current handler before ack adds the new one.
        in_service_n = (in_service_q & ~(eoi_ok ? cur_onehot : '0))
                     | (ack_ok ? id_onehot : '0);

        nest_level_n = nest_level_q;
        if (ack_ok && !eoi_ok) begin
            nest_level_n = nest_level_q + LVL_ONE;
        end else if (eoi_ok && !ack_ok) begin
            nest_level_n = nest_level_q - LVL_ONE;
        end

        int_req_n = (cand != '0) && (nest_level_q < LVL_LIMIT) && !ack_ok;
        int_id_n  = (cand != '0) ? best : int_id_q;

        case (bus.cfg_sel)
            SEL_MASK:  rdata = mask_q;
            SEL_MODE:  rdata = mode_q;
            SEL_PEND:  rdata = pending_q;
            SEL_INSV:  rdata = in_service_q;
            SEL_FLAGS: rdata = {{(N_IRQ-2){1'b0}}, eoi_uflow_q, spur_ack_q};
            default:   rdata = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
            s_d          <= '0;
            mask_q       <= '0;
            mode_q       <= '1;
            pending_q    <= '0;
            in_service_q <= '0;
            int_req_q    <= 1'b0;
            int_id_q     <= '0;
            nest_level_q <= '0;
            spur_ack_q   <= 1'b0;
            eoi_uflow_q  <= 1'b0;
        end else begin
            sync_q[0] <= irq_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
            s_d          <= s;
            if (wr_mask) begin
                mask_q <= bus.cfg_wdata;
            end
            if (wr_mode) begin
                mode_q <= bus.cfg_wdata;
            end
            pending_q    <= pending_n;
            in_service_q <= in_service_n;
            int_req_q    <= int_req_n;
            int_id_q     <= int_id_n;
            nest_level_q <= nest_level_n;
            // A new error event in the same cycle as a flags write wins.
            spur_ack_q   <= (spur_ack_q & ~wr_flags) | (bus.int_ack & ~int_req_q);
            eoi_uflow_q  <= (eoi_uflow_q & ~wr_flags) | (bus.int_eoi & (nest_level_q == '0));
        end
    end

    assign bus.cfg_rdata  = rdata;
    assign bus.int_req    = int_req_q;
    assign bus.int_id     = int_id_q;
    assign bus.nest_level = nest_level_q;
    assign bus.spur_ack   = spur_ack_q;
    assign bus.eoi_uflow  = eoi_uflow_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// tb/tb_irq_ctrl.sv - self-checking bench for irq_ctrl with a stack-based reference model
module tb_irq_ctrl;
    localparam int N  = 8;
    localparam int SS = 2;
    localparam int ND = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] irq_in = '0;
    logic [7:0] irq_in1 = '0;

    always #5 clk = ~clk;

    irq_ctrl_if #(.N_IRQ(8), .ID_W(3), .LVL_W(3)) bus ();
    irq_ctrl_if #(.N_IRQ(8), .ID_W(3), .LVL_W(3)) bus1 ();

    irq_ctrl #(.N_IRQ(8), .ID_W(3), .NEST_DEPTH(ND), .LVL_W(3), .SYNC_STAGES(SS)) dut (
        .clk(clk), .reset(reset), .irq_in(irq_in), .bus(bus)
    );

    irq_ctrl #(.N_IRQ(8), .ID_W(3), .NEST_DEPTH(1), .LVL_W(3), .SYNC_STAGES(SS)) dut1 (
        .clk(clk), .reset(reset), .irq_in(irq_in1), .bus(bus1)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: in-service channels kept as a stack (top = running
    // handler, which is always the lowest index), raw line history as a queue.
    logic [7:0] m_mask = '0, m_mode = '1, m_pend = '0;
    int         stk[$];
    logic       m_req = 1'b0;
    logic [2:0] m_id = '0;
    logic       m_spur = 1'b0, m_uflow = 1'b0;
    logic [7:0] samp[$];

    function automatic logic [7:0] m_inserv();
        logic [7:0] v = '0;
        foreach (stk[k]) v[stk[k]] = 1'b1;
        return v;
    endfunction

    function automatic logic [7:0] m_rdata(input logic [2:0] sel);
        case (sel)
            3'd0: return m_mask;
            3'd1: return m_mode;
            3'd2: return m_pend;
            3'd3: return m_inserv();
            3'd4: return {6'b0, m_uflow, m_spur};
            default: return 8'h00;
        endcase
    endfunction

    logic [7:0] t_s, t_sd, t_flip;
    int         t_cur, t_best;
    bit         t_ack, t_eoi, t_we;
    logic       t_set, t_clr;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_mask = '0; m_mode = '1; m_pend = '0; stk.delete();
            m_req = 1'b0; m_id = '0; m_spur = 1'b0; m_uflow = 1'b0;
            samp.delete();
            for (int k = 0; k <= SS; k++) samp.push_back(8'h00);
        end else begin
            t_s    = samp[SS-1];
            t_sd   = samp[SS];
            t_cur  = (stk.size() > 0) ? stk[$] : N;
            t_best = -1;
            for (int i = 0; i < t_cur; i++)
                if (m_pend[i] && m_mask[i] && t_best < 0) t_best = i;
            t_ack  = bus.int_ack && m_req;
            t_eoi  = bus.int_eoi && (stk.size() > 0);
            t_we   = bus.cfg_we;
            t_flip = (t_we && bus.cfg_sel == 3'd1) ? (bus.cfg_wdata ^ m_mode) : 8'h00;
            for (int i = 0; i < N; i++) begin
                if (t_flip[i]) m_pend[i] = 1'b0;
                else if (!m_mode[i]) m_pend[i] = t_s[i];
                else begin
                    t_set = (t_s[i] && !t_sd[i]) || (t_we && bus.cfg_sel == 3'd3 && bus.cfg_wdata[i]);
                    t_clr = (t_ack && m_id == i[2:0]) || (t_we && bus.cfg_sel == 3'd2 && bus.cfg_wdata[i]);
                    if (t_set) m_pend[i] = 1'b1;
                    else if (t_clr) m_pend[i] = 1'b0;
                end
            end
            m_spur  = (m_spur  && !(t_we && bus.cfg_sel == 3'd4)) || (bus.int_ack && !m_req);
            m_uflow = (m_uflow && !(t_we && bus.cfg_sel == 3'd4)) || (bus.int_eoi && stk.size() == 0);
            m_req   = (t_best >= 0) && (stk.size() < ND) && !t_ack;
            if (t_eoi) void'(stk.pop_back());
            if (t_ack) stk.push_back(int'(m_id));
            if (t_best >= 0) m_id = t_best[2:0];
            if (t_we && bus.cfg_sel == 3'd0) m_mask = bus.cfg_wdata;
            if (t_we && bus.cfg_sel == 3'd1) m_mode = bus.cfg_wdata;
            samp.push_front(irq_in);
            void'(samp.pop_back());
        end
    end

    always @(negedge clk) begin
        chk("int_req", bus.int_req, m_req);
        chk("int_id", bus.int_id, m_id);
        chk("nest_level", bus.nest_level, stk.size());
        chk("spur_ack", bus.spur_ack, m_spur);
        chk("eoi_uflow", bus.eoi_uflow, m_uflow);
        chk("cfg_rdata", bus.cfg_rdata, m_rdata(bus.cfg_sel));
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic cfg_wr(input logic [2:0] sel, input logic [7:0] d);
        bus.cfg_we = 1'b1; bus.cfg_sel = sel; bus.cfg_wdata = d;
        tick(1);
        bus.cfg_we = 1'b0;
    endtask

    task automatic rd(input logic [2:0] sel, output logic [7:0] v);
        bus.cfg_sel = sel;
        #1;
        v = bus.cfg_rdata;
    endtask

    task automatic pulse(input logic [7:0] b);
        irq_in = b; tick(1); irq_in = '0;
    endtask

    task automatic do_ack();
        bus.int_ack = 1'b1; tick(1); bus.int_ack = 1'b0;
    endtask

    task automatic do_eoi();
        bus.int_eoi = 1'b1; tick(1); bus.int_eoi = 1'b0;
    endtask

    logic [7:0] v;
    logic [31:0] r;

    initial begin
        bus.cfg_we = 0; bus.cfg_sel = 0; bus.cfg_wdata = 0; bus.int_ack = 0; bus.int_eoi = 0;
        bus1.cfg_we = 0; bus1.cfg_sel = 0; bus1.cfg_wdata = 0; bus1.int_ack = 0; bus1.int_eoi = 0;

        // Reset held with lines toggling
        for (int k = 0; k < 4; k++) begin irq_in = 8'($urandom); tick(1); end
        chk("rst int_req", bus.int_req, 0);
        chk("rst int_id", bus.int_id, 0);
        chk("rst nest", bus.nest_level, 0);
        chk("rst flags", {bus.eoi_uflow, bus.spur_ack}, 0);
        rd(3'd1, v); chk("rst mode", v, 8'hFF);
        rd(3'd0, v); chk("rst mask", v, 8'h00);
        irq_in = '0;
        tick(2);
        reset = 1'b1;
        tick(1);

        // Masked edges latch but never request
        pulse(8'h5A); tick(6);
        chk("masked no req", bus.int_req, 0);
        rd(3'd2, v); chk("masked pending", v, 8'h5A);
        cfg_wr(3'd2, 8'hFF);
        rd(3'd2, v); chk("w1c pending", v, 8'h00);

        // Edge basic, latency SYNC_STAGES+2
        cfg_wr(3'd0, 8'h08);
        pulse(8'h08); tick(2);
        chk("edge req early", bus.int_req, 0);
        tick(1);
        chk("edge req", bus.int_req, 1);
        chk("edge id", bus.int_id, 3);
        do_ack();
        chk("ack req drop", bus.int_req, 0);
        chk("ack nest", bus.nest_level, 1);
        rd(3'd3, v); chk("ack insv", v, 8'h08);
        rd(3'd2, v); chk("ack pend", v, 8'h00);
        do_eoi();
        chk("eoi nest", bus.nest_level, 0);
        rd(3'd3, v); chk("eoi insv", v, 8'h00);

        // Nesting
        cfg_wr(3'd0, 8'hFF);
        pulse(8'h20); tick(3);
        chk("nest id5", bus.int_id, 5);
        do_ack();
        pulse(8'h04); tick(3);
        chk("nest req2", bus.int_req, 1);
        chk("nest id2", bus.int_id, 2);
        do_ack();
        chk("nest lvl2", bus.nest_level, 2);
        rd(3'd3, v); chk("nest insv", v, 8'h24);
        pulse(8'h40); tick(5);
        chk("ch6 blocked", bus.int_req, 0);
        do_eoi(); tick(2);
        chk("ch6 blocked by 5", bus.int_req, 0);
        do_eoi(); tick(1);
        chk("ch6 req", bus.int_req, 1);
        chk("ch6 id", bus.int_id, 6);
        do_ack(); do_eoi();

        // Priority and simultaneous ack/eoi
        pulse(8'h12); tick(3);
        chk("prio id1", bus.int_id, 1);
        do_ack(); do_eoi(); tick(1);
        chk("prio id4", bus.int_id, 4);
        do_ack();
        pulse(8'h02); tick(3);
        chk("preempt id1", bus.int_id, 1);
        bus.int_ack = 1'b1; bus.int_eoi = 1'b1; tick(1); bus.int_ack = 1'b0; bus.int_eoi = 1'b0;
        chk("ack+eoi nest", bus.nest_level, 1);
        rd(3'd3, v); chk("ack+eoi insv", v, 8'h02);
        do_eoi();

        // Level mode
        cfg_wr(3'd1, 8'hFE);
        irq_in = 8'h01; tick(4);
        chk("lvl req", bus.int_req, 1);
        chk("lvl id", bus.int_id, 0);
        do_ack();
        rd(3'd2, v); chk("lvl pend after ack", v, 8'h01);
        do_eoi(); tick(1);
        chk("lvl rereq", bus.int_req, 1);
        irq_in = 8'h00; tick(5);
        rd(3'd2, v); chk("lvl pend drop", v, 8'h00);
        chk("lvl no req", bus.int_req, 0);
        cfg_wr(3'd1, 8'hFF);

        // Error flags
        do_ack();
        chk("spur", bus.spur_ack, 1);
        do_eoi();
        chk("uflow", bus.eoi_uflow, 1);
        rd(3'd4, v); chk("flags rd", v, 8'h03);
        cfg_wr(3'd4, 8'h00);
        rd(3'd4, v); chk("flags clr", v, 8'h00);

        // Reset mid-handler drops everything
        pulse(8'h09); tick(3);
        do_ack();
        reset = 1'b0; tick(1);
        chk("mid rst nest", bus.nest_level, 0);
        rd(3'd2, v); chk("mid rst pend", v, 8'h00);
        rd(3'd0, v); chk("mid rst mask", v, 8'h00);
        reset = 1'b1; tick(1);

        // NEST_DEPTH=1 instance
        bus1.cfg_we = 1; bus1.cfg_sel = 3'd0; bus1.cfg_wdata = 8'hFF; tick(1); bus1.cfg_we = 0;
        irq_in1 = 8'h20; tick(1); irq_in1 = 8'h00; tick(3);
        chk("d1 id5", bus1.int_id, 5);
        chk("d1 req", bus1.int_req, 1);
        bus1.int_ack = 1; tick(1); bus1.int_ack = 0;
        irq_in1 = 8'h04; tick(1); irq_in1 = 8'h00; tick(5);
        chk("d1 full no req", bus1.int_req, 0);
        bus1.int_eoi = 1; tick(1); bus1.int_eoi = 0; tick(1);
        chk("d1 resume req", bus1.int_req, 1);
        chk("d1 resume id", bus1.int_id, 2);

        // Randomised traffic checked every cycle by the model
        for (int c = 0; c < 3000; c++) begin
            if (c == 1000 || c == 2000) begin
                reset = 1'b0; tick(2); reset = 1'b1;
            end
            r = $urandom;
            irq_in = irq_in ^ (r[7:0] & r[15:8] & r[23:16]);
            bus.int_ack = m_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 39) == 0);
            bus.int_eoi = ($urandom_range(0, 5) == 0);
            bus.cfg_we = ($urandom_range(0, 9) == 0);
            bus.cfg_sel = 3'($urandom_range(0, 7));
            bus.cfg_wdata = 8'($urandom);
            if (bus.cfg_sel == 3'd0) bus.cfg_wdata = bus.cfg_wdata | 8'($urandom);
            tick(1);
        end
        bus.int_ack = 0; bus.int_eoi = 0; bus.cfg_we = 0;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
